l1_burst_mem_ctrl: RTL and testbench

- Sits directly downstream of the data cache's L1 request/response port, in the per-core memory path of the dual-core build.
- Accepts one L1 request at a time and turns it into word beats on a simple pipelined word bus (req/gnt, in-order rvalid).
  - Reads: line bursts.
  - Writes: single-beat writes.
- Streams read words back in line order and owns the LR/SC reservation, driving sc_complete/sc_success.
- The reservation is cleared by writes snooped from the other core.

---
 rtl/l1_burst_mem_ctrl_pkg.sv | 28 ++
 rtl/l1_burst_mem_ctrl_lr_sc_reservation.sv | 57 +++++
 rtl/l1_burst_mem_ctrl.sv | 174 +++++++++++++++++
 tb/tb_l1_burst_mem_ctrl.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/l1_burst_mem_ctrl_pkg.sv
// rtl/l1_burst_mem_ctrl_pkg.sv - shared types and atomic encodings for the L1 burst memory controller
package l1_burst_mem_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD_ISSUE = 3'd1,
        RD_DRAIN = 3'd2,
        WR       = 3'd3,
        SC_RESP  = 3'd4
    } state_e;

    // funct5 encodings carried on req_amo
    localparam logic [4:0] OP_AMOADD  = 5'b00000;
    localparam logic [4:0] OP_AMOSWAP = 5'b00001;
    localparam logic [4:0] OP_LR      = 5'b00010;
    localparam logic [4:0] OP_SC      = 5'b00011;

    typedef struct packed {
        logic [31:0] addr;
        logic        rnw;
        logic [3:0]  be;
        logic [31:0] data;
        logic [4:0]  size;
        logic        is_amo;
        logic [4:0]  amo;
    } l1_req_t;

endpackage

// File: rtl/l1_burst_mem_ctrl_lr_sc_reservation.sv
// rtl/l1_burst_mem_ctrl_lr_sc_reservation.sv - LR/SC reservation register with snoop invalidation
module l1_burst_mem_ctrl_lr_sc_reservation
    import l1_burst_mem_ctrl_pkg::*;
#(
    parameter int LINE_W = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          set_i,
    input  logic [31-$clog2(LINE_W)-2:0]  set_line_i,
    input  logic                          clr_i,
    input  logic                          snoop_valid_i,
    input  logic [29:0]                   snoop_addr_i,
    input  logic [31-$clog2(LINE_W)-2:0]  chk_line_i,
    output logic                          resv_hit_o
);
    localparam int LW = $clog2(LINE_W);
    localparam int LINE_BITS = 30 - LW;

    logic                 valid_q, valid_d;
    logic [LINE_BITS-1:0] line_q, line_d;
    logic [LINE_BITS-1:0] snoop_line;
    logic                 unused_snoop_word;

    assign snoop_line        = snoop_addr_i[29:LW];
    assign unused_snoop_word = ^snoop_addr_i[LW-1:0];

    // A snoop hitting either the held line or the line being set wins over the set
    always_comb begin
        valid_d = valid_q;
        line_d  = line_q;
        if (snoop_valid_i && snoop_line == line_q) begin
            valid_d = 1'b0;
        end
        if (set_i) begin
            valid_d = 1'b1;
            line_d  = set_line_i;
        end
        if (clr_i || (set_i && snoop_valid_i && snoop_line == set_line_i)) begin
            valid_d = 1'b0;
        end
    end

    // Reservation state register
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            line_q  <= '0;
        end else begin
            valid_q <= valid_d;
            line_q  <= line_d;
        end
    end

    assign resv_hit_o = valid_q && (chk_line_i == line_q);

endmodule

// File: rtl/l1_burst_mem_ctrl.sv
// rtl/l1_burst_mem_ctrl.sv - turns L1 requests into word-bus beats, returns read lines, owns LR/SC
module l1_burst_mem_ctrl
    import l1_burst_mem_ctrl_pkg::*;
#(
    parameter int LINE_W = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ack,
    input  logic [31:0] req_addr,
    input  logic        req_rnw,
    input  logic [3:0]  req_be,
    input  logic [31:0] req_data,
    input  logic [4:0]  req_size,
    input  logic        req_is_amo,
    input  logic [4:0]  req_amo,
    output logic        resp_data_valid,
    output logic [31:0] resp_data,
    output logic        sc_complete,
    output logic        sc_success,
    input  logic        snoop_valid,
    input  logic [29:0] snoop_addr,
    output logic        mem_req,
    input  logic        mem_gnt,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);
    localparam int OFF_W = $clog2(LINE_W) + 2;

    state_e      state_q, state_d;
    l1_req_t     req_q, req_d;
    logic [4:0]  issue_cnt_q, issue_cnt_d;
    logic [4:0]  ret_cnt_q, ret_cnt_d;
    logic        ack_q, ack_d;
    logic        resp_valid_q, resp_valid_d;
    logic [31:0] resp_data_q, resp_data_d;
    logic        sc_cmp_q, sc_cmp_d;
    logic        sc_succ_q, sc_succ_d;

    logic        in_is_sc, q_is_sc, q_is_lr;
    logic [31:0] base_addr, beat_addr;
    logic        resv_set, resv_clr, resv_hit;

    assign in_is_sc  = !req_rnw && req_is_amo && (req_amo == OP_SC);
    assign q_is_sc   = !req_q.rnw && req_q.is_amo && (req_q.amo == OP_SC);
    assign q_is_lr   = req_q.rnw && req_q.is_amo && (req_q.amo == OP_LR);
    // Single-word reads go exactly where asked; bursts start at the line base
    assign base_addr = (req_q.size == 5'd0) ? req_q.addr : {req_q.addr[31:OFF_W], {OFF_W{1'b0}}};
    assign beat_addr = base_addr + {25'd0, issue_cnt_q, 2'b00};

    l1_burst_mem_ctrl_lr_sc_reservation #(.LINE_W(LINE_W)) u_resv (
        .clk           (clk),
        .rst           (rst),
        .set_i         (resv_set),
        .set_line_i    (base_addr[31:OFF_W]),
        .clr_i         (resv_clr),
        .snoop_valid_i (snoop_valid),
        .snoop_addr_i  (snoop_addr),
        .chk_line_i    (req_addr[31:OFF_W]),
        .resv_hit_o    (resv_hit)
    );

    // Next-state, bus drive and response pipeline decisions
    always_comb begin
        state_d      = state_q;
        req_d        = req_q;
        issue_cnt_d  = issue_cnt_q;
        ret_cnt_d    = ret_cnt_q;
        ack_d        = 1'b0;
        resp_valid_d = 1'b0;
        resp_data_d  = resp_data_q;
        sc_cmp_d     = 1'b0;
        sc_succ_d    = 1'b0;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = 32'h0;
        resv_set     = 1'b0;
        resv_clr     = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    req_d       = '{addr: req_addr, rnw: req_rnw, be: req_be, data: req_data,
                                    size: req_size, is_amo: req_is_amo, amo: req_amo};
                    ack_d       = 1'b1;
                    issue_cnt_d = 5'd0;
                    ret_cnt_d   = 5'd0;
                    if (req_rnw) begin
                        state_d = RD_ISSUE;
                    end else if (in_is_sc) begin
                        resv_clr = 1'b1;
                        state_d  = resv_hit ? WR : SC_RESP;
                    end else begin
                        state_d = WR;
                    end
                end
            end
            RD_ISSUE: begin
                mem_req  = 1'b1;
                mem_addr = beat_addr;
                if (mem_gnt) begin
                    issue_cnt_d = issue_cnt_q + 5'd1;
                    if (issue_cnt_q == req_q.size) begin
                        state_d = RD_DRAIN;
                    end
                end
            end
            RD_DRAIN: begin
                if (mem_rvalid && ret_cnt_q == req_q.size) begin
                    state_d  = IDLE;
                    resv_set = q_is_lr;
                end
            end
            WR: begin
                mem_req  = 1'b1;
                mem_we   = 1'b1;
                mem_addr = req_q.addr;
                if (mem_gnt) begin
                    state_d   = IDLE;
                    sc_cmp_d  = q_is_sc;
                    sc_succ_d = q_is_sc;
                end
            end
            SC_RESP: begin
                sc_cmp_d = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if ((state_q == RD_ISSUE || state_q == RD_DRAIN) && mem_rvalid) begin
            resp_valid_d = 1'b1;
            resp_data_d  = mem_rdata;
            ret_cnt_d    = ret_cnt_q + 5'd1;
        end
    end

    // Registered state, latched request and pulse outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            req_q        <= '0;
            issue_cnt_q  <= 5'd0;
            ret_cnt_q    <= 5'd0;
            ack_q        <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= 32'h0;
            sc_cmp_q     <= 1'b0;
            sc_succ_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            req_q        <= req_d;
            issue_cnt_q  <= issue_cnt_d;
            ret_cnt_q    <= ret_cnt_d;
            ack_q        <= ack_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            sc_cmp_q     <= sc_cmp_d;
            sc_succ_q    <= sc_succ_d;
        end
    end

    assign req_ack         = ack_q;
    assign resp_data_valid = resp_valid_q;
    assign resp_data       = resp_data_q;
    assign sc_complete     = sc_cmp_q;
    assign sc_success      = sc_succ_q;
    assign mem_be          = req_q.be;
    assign mem_wdata       = req_q.data;

endmodule

// File: tb/tb_l1_burst_mem_ctrl.sv
// tb/tb_l1_burst_mem_ctrl.sv - directed scoreboard bench for l1_burst_mem_ctrl
module tb_l1_burst_mem_ctrl;
    import l1_burst_mem_ctrl_pkg::*;

    localparam int P = 10;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ack;
    logic [31:0] req_addr;
    logic        req_rnw;
    logic [3:0]  req_be;
    logic [31:0] req_data;
    logic [4:0]  req_size;
    logic        req_is_amo;
    logic [4:0]  req_amo;
    logic        resp_data_valid;
    logic [31:0] resp_data;
    logic        sc_complete;
    logic        sc_success;
    logic        snoop_valid;
    logic [29:0] snoop_addr;
    logic        mem_req;
    logic        mem_gnt;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    l1_burst_mem_ctrl #(.LINE_W(4)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ack(req_ack), .req_addr(req_addr), .req_rnw(req_rnw),
        .req_be(req_be), .req_data(req_data), .req_size(req_size),
        .req_is_amo(req_is_amo), .req_amo(req_amo),
        .resp_data_valid(resp_data_valid), .resp_data(resp_data),
        .sc_complete(sc_complete), .sc_success(sc_success),
        .snoop_valid(snoop_valid), .snoop_addr(snoop_addr),
        .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #(P/2) clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        int          stall;
        logic        snoop_last;
    } beat_t;

    beat_t       exp_beats[$];
    logic [31:0] exp_resp[$];
    logic        exp_sc[$];
    logic [31:0] mem_model [logic [31:0]];

    int  n_pass = 0, n_total = 0, n_fail = 0;
    int  ack_total = 0, req_total = 0, gnt_total = 0;
    int  snoop_req_cnt = 0, snoop_done_cnt = 0;
    logic [29:0] snoop_req_addr;
    time wr_gnt_t = 0, sc_t = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push_beat(input logic [31:0] a, input logic we, input logic [3:0] be,
                             input logic [31:0] d, input int stall, input logic snl);
        beat_t b;
        b.addr = a; b.we = we; b.be = be; b.wdata = d; b.stall = stall; b.snoop_last = snl;
        exp_beats.push_back(b);
    endtask

    // Pipelined word bus: gnt after a per-beat stall, rvalid two cycles after gnt
    initial begin : bus_model
        logic        pv0, pv1, ps0, ps1;
        logic [31:0] pd0, pd1, pa0, pa1;
        int          stall_cnt;
        beat_t       h;
        pv0 = 0; pv1 = 0; ps0 = 0; ps1 = 0; pd0 = 0; pd1 = 0; pa0 = 0; pa1 = 0;
        stall_cnt = 0;
        mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0; snoop_valid = 0; snoop_addr = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                pv0 = 0; pv1 = 0; ps0 = 0; ps1 = 0; stall_cnt = 0;
                mem_gnt = 0; mem_rvalid = 0; snoop_valid = 0;
            end else begin
                mem_rvalid  = pv1;
                mem_rdata   = pv1 ? pd1 : 32'h0;
                snoop_valid = 0;
                if (pv1 && ps1) begin
                    snoop_valid = 1;
                    snoop_addr  = pa1[31:2];
                end else if (snoop_done_cnt != snoop_req_cnt) begin
                    snoop_valid = 1;
                    snoop_addr  = snoop_req_addr;
                    snoop_done_cnt++;
                end
                pv1 = pv0; pd1 = pd0; ps1 = ps0; pa1 = pa0;
                pv0 = 0; ps0 = 0;
                mem_gnt = 0;
                if (!mem_req && stall_cnt != 0) begin
                    check("req_held_during_stall", 32'(mem_req), 32'd1);
                    stall_cnt = 0;
                end
                if (mem_req) begin
                    check("beat_expected", 32'(exp_beats.size() != 0), 32'd1);
                    if (exp_beats.size() != 0) begin
                        h = exp_beats[0];
                        check("beat_addr", mem_addr, h.addr);
                        check("beat_we", 32'(mem_we), 32'(h.we));
                        if (h.we) begin
                            check("beat_be", 32'(mem_be), 32'(h.be));
                            check("beat_wdata", mem_wdata, h.wdata);
                        end
                        if (stall_cnt == h.stall) begin
                            mem_gnt = 1;
                            gnt_total++;
                            stall_cnt = 0;
                            void'(exp_beats.pop_front());
                            if (h.we) begin
                                wr_gnt_t = $time;
                            end else begin
                                pv0 = 1;
                                pa0 = h.addr;
                                ps0 = h.snoop_last;
                                pd0 = mem_model.exists(h.addr) ? mem_model[h.addr] : 32'hBAD0_0000;
                            end
                        end else begin
                            stall_cnt++;
                        end
                    end
                end
            end
        end
    end

    // Output monitor: pops the scoreboard as responses appear
    initial begin : monitor
        forever begin
            @(negedge clk);
            if (req_ack) ack_total++;
            if (resp_data_valid) begin
                check("resp_expected", 32'(exp_resp.size() != 0), 32'd1);
                if (exp_resp.size() != 0) check("resp_data", resp_data, exp_resp.pop_front());
            end
            if (sc_complete) begin
                sc_t = $time;
                check("sc_expected", 32'(exp_sc.size() != 0), 32'd1);
                if (exp_sc.size() != 0) check("sc_success", 32'(sc_success), 32'(exp_sc.pop_front()));
            end
        end
    end

    initial begin : watchdog
        #(50000 * P);
        $display("FAIL watchdog timeout observed=hang expected=finish");
        $fatal(1);
    end

    task automatic issue(input logic [31:0] a, input logic rnw, input logic [3:0] be,
                         input logic [31:0] d, input logic [4:0] sz, input logic amo_en,
                         input logic [4:0] amo, output time t_ack);
        int n;
        @(negedge clk);
        req_valid = 1; req_addr = a; req_rnw = rnw; req_be = be; req_data = d;
        req_size = sz; req_is_amo = amo_en; req_amo = amo;
        req_total++;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!req_ack && n < 200);
        t_ack = $time;
        check("req_ack", 32'(req_ack), 32'd1);
        @(negedge clk);
        req_valid = 0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_beats.size() != 0 || exp_resp.size() != 0 || exp_sc.size() != 0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("drain_in_time", 32'(n < 300), 32'd1);
        repeat (2) @(negedge clk);
    endtask

    initial begin : stimulus
        time t_a;
        int  g0;
        rst = 1; req_valid = 0; req_addr = 0; req_rnw = 0; req_be = 0; req_data = 0;
        req_size = 0; req_is_amo = 0; req_amo = 0; snoop_req_addr = 0;
        for (int i = 0; i < 4; i++) begin
            mem_model[32'h1000 + 4*i] = 32'hA000_0000 + i;
            mem_model[32'h3000 + 4*i] = 32'hC000_3000 + i;
        end
        mem_model[32'h2004] = 32'hB000_2004;

        repeat (3) @(negedge clk);
        check("reset_outputs", 32'({req_ack, resp_data_valid, sc_complete, sc_success, mem_req, mem_we}), 32'd0);
        rst = 0;

        // line read from the middle of a line
        for (int i = 0; i < 4; i++) begin
            push_beat(32'h1000 + 4*i, 0, 0, 0, 0, 0);
            exp_resp.push_back(32'hA000_0000 + i);
        end
        issue(32'h1008, 1, 4'h0, 0, 5'd3, 0, 5'd0, t_a);
        drain();

        // uncached single-word read
        push_beat(32'h2004, 0, 0, 0, 0, 0);
        exp_resp.push_back(32'hB000_2004);
        issue(32'h2004, 1, 4'h0, 0, 5'd0, 0, 5'd0, t_a);
        drain();

        // store stalled three cycles, followed by a read held off until the grant
        push_beat(32'h4000, 1, 4'b0011, 32'hDEAD_BEEF, 3, 0);
        push_beat(32'h2004, 0, 0, 0, 0, 0);
        exp_resp.push_back(32'hB000_2004);
        issue(32'h4000, 0, 4'b0011, 32'hDEAD_BEEF, 5'd0, 0, 5'd0, t_a);
        issue(32'h2004, 1, 4'h0, 0, 5'd0, 0, 5'd0, t_a);
        check("ack_after_store_gnt", 32'(t_a - wr_gnt_t), 32'(2 * P));
        drain();

        // LR then matching SC succeeds, second SC fails
        for (int i = 0; i < 4; i++) begin
            push_beat(32'h3000 + 4*i, 0, 0, 0, 0, 0);
            exp_resp.push_back(32'hC000_3000 + i);
        end
        issue(32'h3000, 1, 4'h0, 0, 5'd3, 1, OP_LR, t_a);
        drain();
        push_beat(32'h3004, 1, 4'hF, 32'h55, 0, 0);
        exp_sc.push_back(1'b1);
        issue(32'h3004, 0, 4'hF, 32'h55, 5'd0, 1, OP_SC, t_a);
        drain();
        check("sc_ok_latency", 32'(sc_t - wr_gnt_t), 32'(P));
        exp_sc.push_back(1'b0);
        issue(32'h3004, 0, 4'hF, 32'h66, 5'd0, 1, OP_SC, t_a);
        drain();
        check("sc_fail_latency", 32'(sc_t - t_a), 32'(P));

        // LR, snoop to the same line, SC fails
        for (int i = 0; i < 4; i++) begin
            push_beat(32'h3000 + 4*i, 0, 0, 0, 0, 0);
            exp_resp.push_back(32'hC000_3000 + i);
        end
        issue(32'h3000, 1, 4'h0, 0, 5'd3, 1, OP_LR, t_a);
        drain();
        snoop_req_addr = 30'(32'h3008 >> 2);
        snoop_req_cnt++;
        repeat (3) @(negedge clk);
        exp_sc.push_back(1'b0);
        issue(32'h3000, 0, 4'hF, 32'h77, 5'd0, 1, OP_SC, t_a);
        drain();

        // snoop on the cycle of the final LR word: reservation never becomes valid
        for (int i = 0; i < 4; i++) begin
            push_beat(32'h3000 + 4*i, 0, 0, 0, 0, (i == 3));
            exp_resp.push_back(32'hC000_3000 + i);
        end
        issue(32'h3000, 1, 4'h0, 0, 5'd3, 1, OP_LR, t_a);
        drain();
        exp_sc.push_back(1'b0);
        issue(32'h3000, 0, 4'hF, 32'h88, 5'd0, 1, OP_SC, t_a);
        drain();

        // reset during RD_ISSUE after two grants
        for (int i = 0; i < 4; i++) begin
            push_beat(32'h1000 + 4*i, 0, 0, 0, 0, 0);
            exp_resp.push_back(32'hA000_0000 + i);
        end
        g0 = gnt_total - 0;
        g0 = gnt_total;
        issue(32'h1000, 1, 4'h0, 0, 5'd3, 0, 5'd0, t_a);
        begin : wait_two
            int n;
            n = 0;
            do begin
                @(posedge clk);
                n++;
            end while (gnt_total - g0 < 2 && n < 50);
            check("two_grants_seen", 32'(gnt_total - g0 >= 2), 32'd1);
        end
        #1 rst = 1;
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        check("reset_mid_burst_outputs",
              32'({req_ack, resp_data_valid, sc_complete, sc_success, mem_req, mem_we}), 32'd0);
        exp_beats.delete();
        exp_resp.delete();
        rst = 0;
        repeat (3) @(negedge clk);
        push_beat(32'h2004, 0, 0, 0, 0, 0);
        exp_resp.push_back(32'hB000_2004);
        issue(32'h2004, 1, 4'h0, 0, 5'd0, 0, 5'd0, t_a);
        drain();

        check("ack_count", 32'(ack_total), 32'(req_total));
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
